// File: rtl/lsu_dp.sv
// rtl/lsu_dp.sv - load/store data path: one CPU request per three cycles onto a single-cycle data port
// Optional misaligned-access trap enabled by defining LSU_DP_MISALIGN_TRAP_EN.
module lsu_dp (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic [31:0] dp_address,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  output logic        read_dp,
  output logic        write_dp,
  input  logic [31:0] dp_data
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        w_accept;
  logic        w_in_access;
  logic        w_misalign;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_accept    = req_valid && req_ready;
  assign w_in_access = (r_state == S_ACCESS) && !rst;

`ifdef LSU_DP_MISALIGN_TRAP_EN
  logic r_err;

  assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
  assign resp_err   = r_err;
`else
  assign w_misalign = 1'b0;
  assign resp_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Handshake and status outputs are gated by rst so they read idle during the reset cycle itself.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = !rst;
        if (w_accept) begin
          w_next = w_misalign ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        busy   = !rst;
        w_next = S_RESP;
      end
      S_RESP: begin
        busy       = !rst;
        resp_valid = !rst;
        w_next     = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= 2'b00;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
    end else if (w_accept) begin
      r_write  <= req_write;
      r_signed <= req_signed;
      r_size   <= req_size;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
    end
  end

  assign read_dp    = w_in_access && !r_write;
  assign write_dp   = w_in_access && r_write;
  assign dp_address = w_in_access ? {r_addr[31:2], 2'b00} : 32'd0;

  always_comb begin
    byteenable = 4'b0000;
    if (w_in_access) begin
      case (r_size)
        2'b00:   byteenable = 4'b0001 << r_addr[1:0];
        2'b01:   byteenable = r_addr[1] ? 4'b1100 : 4'b0011;
        default: byteenable = 4'b1111;
      endcase
    end
  end

  always_comb begin
    case (r_size)
      2'b00:   writedata = {4{r_wdata[7:0]}};
      2'b01:   writedata = {2{r_wdata[15:0]}};
      default: writedata = r_wdata;
    endcase
  end

  always_comb begin
    w_byte = dp_data[7:0];
    case (r_addr[1:0])
      2'b01:   w_byte = dp_data[15:8];
      2'b10:   w_byte = dp_data[23:16];
      2'b11:   w_byte = dp_data[31:24];
      default: w_byte = dp_data[7:0];
    endcase
    w_half = r_addr[1] ? dp_data[31:16] : dp_data[15:0];
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = dp_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'd0;
    end else if (r_state == S_ACCESS) begin
      r_rdata <= r_write ? 32'd0 : w_load;
    end else if (w_accept && w_misalign) begin
      r_rdata <= 32'd0;
    end
  end

`ifdef LSU_DP_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (r_state == S_ACCESS) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_misalign;
    end
  end
`endif

  assign resp_rdata = r_rdata;

endmodule

// File: tb/tb_lsu_dp.sv
// tb/tb_lsu_dp.sv - self-checking bench for lsu_dp with a byte-level memory model and per-cycle compare
module tb_lsu_dp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic [31:0] dp_address;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        read_dp;
  logic        write_dp;
  logic [31:0] dp_data;

  always #5 clk = ~clk;

  lsu_dp dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
    .dp_address(dp_address), .writedata(writedata), .byteenable(byteenable),
    .read_dp(read_dp), .write_dp(write_dp), .dp_data(dp_data)
  );

  // Data-port memory seen by the DUT
  logic [31:0] mem [0:1023];

  always_comb begin
    dp_data = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (byteenable[i]) dp_data[8*i +: 8] = mem[dp_address[11:2]][8*i +: 8];
    end
  end

  always @(posedge clk) begin
    if (write_dp) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) mem[dp_address[11:2]][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

  // Reference model: flat byte memory plus the expected timeline of the transaction in flight
  logic [7:0]  refmem [0:4095];
  int          cyc = 0;
  int          exp_acc_cyc = -1;
  int          exp_resp_cyc = -1;
  int          bsy_lo = -1;
  int          bsy_hi = -2;
  logic        exp_rd = 1'b0;
  logic        exp_wr = 1'b0;
  logic [3:0]  exp_be = 4'd0;
  logic [31:0] exp_addr = 32'd0;
  logic [31:0] exp_wd = 32'd0;
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_err = 1'b0;
  logic [31:0] held_rdata = 32'd0;
  logic        held_err = 1'b0;
  logic [3:0]  seen_be = 4'd0;
  logic [31:0] seen_wd = 32'd0;
  logic [31:0] seen_rdata = 32'd0;
  logic        seen_err = 1'b0;
  int          n_resp = 0;
  bit          checking = 1'b0;
  int          checks = 0;
  int          failures = 0;
  logic        c_acc, c_rv, c_bsy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      c_acc = !rst && (cyc == exp_acc_cyc);
      c_rv  = !rst && (cyc == exp_resp_cyc);
      c_bsy = !rst && (cyc >= bsy_lo) && (cyc <= bsy_hi);
      chk("read_dp", read_dp, c_acc && exp_rd);
      chk("write_dp", write_dp, c_acc && exp_wr);
      chk("byteenable", byteenable, c_acc ? exp_be : 4'b0000);
      if (c_acc) begin
        chk("dp_address", dp_address, exp_addr);
        if (exp_wr) chk("writedata", writedata, exp_wd);
        seen_be = byteenable;
        seen_wd = writedata;
      end
      chk("resp_valid", resp_valid, c_rv);
      chk("busy", busy, c_bsy);
      chk("req_ready", req_ready, !rst && !c_bsy);
      if (resp_valid) n_resp++;
      if (rst) begin
        held_rdata = 32'd0;
        held_err   = 1'b0;
      end else begin
        if (c_rv) begin
          held_rdata = exp_rdata;
          held_err   = exp_err;
          seen_rdata = resp_rdata;
          seen_err   = resp_err;
        end
        chk("resp_rdata", resp_rdata, held_rdata);
        chk("resp_err", resp_err, held_err);
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    mem[a[11:2]] <= w;
    for (int k = 0; k < 4; k++) refmem[{a[11:2], 2'b00} + 12'(k)] = w[8*k +: 8];
  endtask

  // Issue one request; predicts outcome from refmem when the accepting edge is known.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input bit abort, input bit keep,
                       output int n, output logic [31:0] mv, output logic [3:0] mbe);
    bit         acc = 1'b0;
    logic       mis = 1'b0;
    int         nb;
    logic [11:0] b;
    n = -1; mv = 32'd0; mbe = 4'd0;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    for (int t = 0; t < 12 && !acc; t++) begin
      @(negedge clk);
      if (req_ready) acc = 1'b1;
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL accept_timeout: got no accept want accept for addr 0x%08h", a);
      req_valid = 1'b0;
      return;
    end
    n = cyc + 1;
`ifdef LSU_DP_MISALIGN_TRAP_EN
    mis = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`endif
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    b = a[11:0];
    if (nb == 2) b[0] = 1'b0;
    if (nb == 4) b[1:0] = 2'b00;
    for (int k = 0; k < nb; k++) mbe[b[1:0] + 2'(k)] = 1'b1;
    for (int k = 0; k < 4; k++) exp_wd[8*k +: 8] = wd[8*(k % nb) +: 8];
    if (w) begin
      if (!mis && !abort) for (int k = 0; k < nb; k++) refmem[b + 12'(k)] = wd[8*k +: 8];
    end else if (!mis) begin
      for (int k = 0; k < nb; k++) mv[8*k +: 8] = refmem[b + 12'(k)];
      if (sg && nb == 1) mv[31:8]  = {24{mv[7]}};
      if (sg && nb == 2) mv[31:16] = {16{mv[15]}};
    end
    exp_be = mbe; exp_addr = {a[31:2], 2'b00}; exp_rd = !w; exp_wr = w;
    exp_rdata = mv; exp_err = mis;
    exp_acc_cyc  = mis ? -1 : n;
    exp_resp_cyc = mis ? n : n + 1;
    bsy_lo = n;
    bsy_hi = mis ? n : n + 1;
    @(posedge clk); #1;
    if (!keep) req_valid = 1'b0;
    if (abort) begin
      rst = 1'b1;
      exp_acc_cyc = -1; exp_resp_cyc = -1; bsy_hi = -2;
      @(posedge clk); #1;
      rst = 1'b0;
    end
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int n0, n1, n2, nr;
    logic [31:0] mv;
    logic [3:0]  mbe;
    for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
    for (int i = 0; i < 4096; i++) refmem[i] = 8'd0;
    preload(32'h100, 32'h8001_1234);
    preload(32'h104, 32'h0102_0304);
    preload(32'h108, 32'h55AA_55AA);
    preload(32'h200, 32'hCAFE_F00D);
    preload(32'h300, 32'h0000_A5C3);
    repeat (3) @(posedge clk);
    #1 checking = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", req_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rdata", resp_rdata, 32'd0);
    chk("reset_be", byteenable, 4'd0);
    @(posedge clk); #1;

    issue(1'b0, 2'b01, 1'b1, 32'h102, 32'd0, 1'b0, 1'b0, n0, mv, mbe); settle();
    chk("m_lh_s_be", mbe, 4'b1100);
    chk("m_lh_s", mv, 32'hFFFF_8001);
    chk("dut_lh_s_be", seen_be, 4'b1100);
    chk("dut_lh_s", seen_rdata, 32'hFFFF_8001);
    issue(1'b0, 2'b01, 1'b0, 32'h100, 32'd0, 1'b0, 1'b0, n0, mv, mbe); settle();
    chk("m_lhu", mv, 32'h0000_1234);
    chk("dut_lhu", seen_rdata, 32'h0000_1234);

    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0, n0, mv, mbe); settle();
    chk("dut_sw_be", seen_be, 4'b1111);
    chk("dut_sw_wd", seen_wd, 32'hDEAD_BEEF);
    chk("dut_sw_rdata", seen_rdata, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 1'b0, 1'b0, n0, mv, mbe); settle();
    chk("m_lw", mv, 32'hDEAD_BEEF);
    chk("dut_lw", seen_rdata, 32'hDEAD_BEEF);

    issue(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_0080, 1'b0, 1'b0, n0, mv, mbe); settle();
    chk("dut_sb_be", seen_be, 4'b1000);
    chk("dut_sb_wd", seen_wd, 32'h8080_8080);
    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'd0, 1'b0, 1'b0, n0, mv, mbe); settle();
    chk("m_lb_s", mv, 32'hFFFF_FF80);
    chk("dut_lb_s", seen_rdata, 32'hFFFF_FF80);
    issue(1'b0, 2'b00, 1'b0, 32'h103, 32'd0, 1'b0, 1'b0, n0, mv, mbe); settle();
    chk("dut_lbu", seen_rdata, 32'h0000_0080);

    issue(1'b1, 2'b01, 1'b0, 32'h302, 32'h1234_BEEF, 1'b0, 1'b0, n0, mv, mbe); settle();
    chk("dut_sh_wd", seen_wd, 32'hBEEF_BEEF);
    chk("dut_sh_be", seen_be, 4'b1100);
    issue(1'b0, 2'b11, 1'b0, 32'h300, 32'd0, 1'b0, 1'b0, n0, mv, mbe); settle();
    chk("dut_lw_size3", seen_rdata, 32'hBEEF_A5C3);

    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 1'b0, 1'b1, n0, mv, mbe);
    issue(1'b0, 2'b10, 1'b0, 32'h104, 32'd0, 1'b0, 1'b1, n1, mv, mbe);
    chk("m_b2b_mid", mv, 32'h0102_0304);
    issue(1'b0, 2'b10, 1'b0, 32'h108, 32'd0, 1'b0, 1'b0, n2, mv, mbe); settle();
    chk("b2b_gap1", 32'(n1 - n0), 32'd3);
    chk("b2b_gap2", 32'(n2 - n1), 32'd3);
    chk("dut_b2b_last", seen_rdata, 32'h55AA_55AA);

    nr = n_resp;
    issue(1'b1, 2'b10, 1'b0, 32'h200, 32'h1234_5678, 1'b1, 1'b0, n0, mv, mbe);
    repeat (2) @(posedge clk); #1;
    chk("abort_no_resp", 32'(n_resp), 32'(nr));
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'd0, 1'b0, 1'b0, n0, mv, mbe); settle();
    chk("dut_abort_keep", seen_rdata, 32'hCAFE_F00D);

    issue(1'b0, 2'b10, 1'b0, 32'h101, 32'd0, 1'b0, 1'b0, n0, mv, mbe); settle();
`ifdef LSU_DP_MISALIGN_TRAP_EN
    chk("dut_trap_rdata", seen_rdata, 32'd0);
    chk("dut_trap_err", seen_err, 1'b1);
`else
    chk("dut_mis_rdata", seen_rdata, 32'h80AD_BEEF);
    chk("dut_mis_err", seen_err, 1'b0);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_dp.md
LSU_DP -- requirements
Module: lsu_dp

Interface
REQ-001 The block SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high (all state sampled on posedge clk).
REQ-002 CPU side SHALL be: req_valid in 1 request; req_ready out 1 accept; req_write in 1 store=1/load=0; req_size in 2 (00 byte, 01 half, 10 word, 11 treated as word); req_signed in 1 sign-extend loads; req_addr in 32 byte address; req_wdata in 32 store data (LSBs used).
REQ-003 Response side SHALL be: resp_valid out 1 one-cycle pulse; resp_rdata out 32 extended load data (0 for stores); resp_err out 1 misaligned-access flag; busy out 1 transaction in flight.
REQ-004 Memory side (to data port) SHALL be: dp_address out 32 word-aligned address; writedata out 32 lane-positioned data; byteenable out 4; read_dp out 1; write_dp out 1; dp_data in 32 (combinational read data, byte lane n = address+n, disabled lanes read 0).

Function
REQ-005 FSM SHALL have states IDLE, ACCESS, RESP; req_ready=1 only in IDLE with rst low.
REQ-006 Handshake: req_valid&req_ready at a posedge SHALL latch addr, size, signed, write, wdata, then move IDLE->ACCESS; req_valid in other states ignored.
REQ-007 In ACCESS, dp_address SHALL equal {latched addr[31:2],2'b00}; read_dp=!write, write_dp=write; both 0 in all other states and whenever rst=1.
REQ-008 byteenable SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111; 4'b0000 outside ACCESS.
REQ-009 writedata SHALL replicate data into lanes: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-010 ACCESS SHALL last exactly one cycle; dp_data sampled at its closing edge; ACCESS->RESP unconditionally.
REQ-011 Load extraction: byte = lane addr[1:0], half = lanes {addr[1],0..1}; zero-extend when req_signed=0, sign-extend from bit 7/15 when 1; word unchanged.
REQ-012 RESP SHALL assert resp_valid=1 for exactly one cycle with registered resp_rdata/resp_err, then RESP->IDLE.
REQ-013 Latency SHALL be fixed: accept edge N, resp_valid high in cycle N+2; next accept no earlier than edge N+3 (throughput 1 per 3 cycles).
REQ-014 busy SHALL be 1 in ACCESS and RESP, 0 in IDLE.
REQ-015 resp_rdata and resp_err SHALL hold their last values when resp_valid=0; stores SHALL return resp_rdata=0.

Reset
REQ-016 rst=1 SHALL force IDLE, clear latched request, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, byteenable=0.
REQ-017 rst asserted during ACCESS SHALL abort the transaction with no memory write (write_dp gated low) and no resp_valid pulse.
REQ-018 req_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.

Configuration
REQ-019 Macro LSU_DP_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL skip ACCESS (no read_dp/write_dp), go IDLE->RESP directly, and pulse resp_valid with resp_err=1, resp_rdata=0 one cycle after accept.
REQ-020 Macro undefined: resp_err SHALL be tied 0; misaligned low address bits SHALL be ignored (half uses addr[1], word uses addr[31:2]) and the access completes normally.

Verification
REQ-021 Store word 0xDEADBEEF @0x100, then load word @0x100 -> byteenable 4'b1111 in ACCESS, resp_rdata=0xDEADBEEF in cycle N+2.
REQ-022 Store byte 0x80 @0x103, load byte signed @0x103 -> byteenable 4'b1000, writedata 0x80808080, resp_rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-023 Load half signed @0x102 over memory word 0x8001xxxx -> byteenable 4'b1100, resp_rdata=0xFFFF8001.
REQ-024 req_valid held high continuously for three loads -> accepts at edges 0,3,6; resp_valid in cycles 2,5,8; req_ready low otherwise.
REQ-025 Store word 0x12345678 @0x200 with rst pulsed during ACCESS, then load @0x200 -> original contents returned, no resp_valid for the aborted store.
REQ-026 With LSU_DP_MISALIGN_TRAP_EN: load word @0x101 -> no read_dp, resp_valid one cycle after accept with resp_err=1, resp_rdata=0; without macro: same request reads word @0x100, resp_err=0.
